// File: rtl/event_logger.sv
// Timestamped event log: captures a stable copy of the time-of-day bus and
// stores {stamp, code} per event in a circular buffer that overwrites the oldest entry.
module event_logger #(
  parameter int DEPTH  = 16,
  parameter int CODE_W = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [16:0]                 horario,
  input  logic                        evt_valid,
  input  logic [CODE_W-1:0]           evt_code,
  input  logic                        rd_en,
  output logic [17+CODE_W-1:0]        rd_data,
  output logic                        rd_valid,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty,
  output logic                        full,
  output logic                        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 17 + CODE_W;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [16:0]   sample_q, stamp_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          rd_valid_q, rd_valid_d;
  logic [EW-1:0] rd_data_q, rd_data_d;
  logic [EW-1:0] mem [DEPTH];

  logic wr, pop, is_full;

  always_comb begin
    wr      = evt_valid;
    pop     = rd_en && (count_q != '0);
    is_full = (count_q == FULL_CNT);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_valid_d = pop;
    rd_data_d  = rd_data_q;

    if (pop) begin
      rd_data_d = mem[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end

    if (wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      // Full with no pop: the oldest entry is dropped by advancing the read side too.
      if (is_full && !pop) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        overflow_d = 1'b1;
      end
    end

    unique case ({wr, pop})
      2'b10:   if (!is_full) count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q   <= '0;
      stamp_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      // horario is asynchronous; only a value seen identically on two edges is trusted.
      sample_q <= horario;
      if (sample_q == horario) stamp_q <= sample_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && wr) mem[wr_ptr_q] <= {stamp_q, evt_code};
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_event_logger.sv
// Scoreboard bench for event_logger: the driver queues expected pops, a
// negedge monitor compares every rd_valid strobe against that queue.
module tb_event_logger;

  localparam int DEPTH  = 16;
  localparam int CODE_W = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] horario;
  logic        evt_valid;
  logic [2:0]  evt_code;
  logic        rd_en;
  logic [19:0] rd_data;
  logic        rd_valid;
  logic [4:0]  count;
  logic        empty, full, overflow;

  event_logger #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
    .clk(clk), .reset(reset), .horario(horario),
    .evt_valid(evt_valid), .evt_code(evt_code), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [19:0] model[$];
  logic [19:0] exp_q[$];
  logic [16:0] exp_stamp;
  logic        exp_ovf;

  function automatic logic [16:0] tod(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected pop.
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_valid_unexpected: got rd_valid=1 data=%0h expected rd_valid=0", rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data, e);
        end
      end
    end
  end

  // One clock cycle of stimulus, applied just after a negedge.
  task automatic do_cycle(input logic wr, input logic [2:0] code, input logic rd);
    evt_valid = wr;
    evt_code  = code;
    rd_en     = rd;
    if (rd && model.size() > 0) exp_q.push_back(model.pop_front());
    if (wr) begin
      if (model.size() == DEPTH) begin
        void'(model.pop_front());
        exp_ovf = 1'b1;
      end
      model.push_back({exp_stamp, code});
    end
    @(negedge clk);
    evt_valid = 1'b0;
    rd_en     = 1'b0;
  endtask

  task automatic apply_reset(input logic rd);
    reset = 1'b1;
    rd_en = rd;
    @(negedge clk);
    reset = 1'b0;
    rd_en = 1'b0;
    model.delete();
    exp_ovf   = 1'b0;
    exp_stamp = '0;
  endtask

  task automatic settle();
    repeat (3) do_cycle(1'b0, 3'd0, 1'b0);
    exp_stamp = horario;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"},    32'(count),    32'(model.size()));
    check({tag, "_empty"},    32'(empty),    32'(model.size() == 0));
    check({tag, "_full"},     32'(full),     32'(model.size() == DEPTH));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; horario = '0; evt_valid = 1'b0; evt_code = '0; rd_en = 1'b0;
    exp_stamp = '0; exp_ovf = 1'b0;
    @(negedge clk);
    apply_reset(1'b0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data",  32'(rd_data),  32'd0);
    check_status("reset");

    // Pops while empty are ignored.
    repeat (3) begin
      do_cycle(1'b0, 3'd0, 1'b1);
      check_status("empty_pop");
    end

    // Basic write / read with a stable timestamp.
    horario = tod(1, 2, 3);
    settle();
    do_cycle(1'b1, 3'b101, 1'b0);
    check("one_count", 32'(count), 32'd1);
    do_cycle(1'b0, 3'd0, 1'b1);
    check("one_rd_valid", 32'(rd_valid), 32'd1);
    check("one_rd_data_lit", 32'(rd_data), 32'h0841D); // {1,2,3,101}
    do_cycle(1'b0, 3'd0, 1'b0);
    check("hold_rd_valid", 32'(rd_valid), 32'd0);
    check("hold_rd_data", 32'(rd_data), 32'h0841D);

    // Stability filter: a pulse one cycle after the change logs the old time.
    horario = tod(0, 0, 10);
    do_cycle(1'b0, 3'd0, 1'b0);
    do_cycle(1'b1, 3'd2, 1'b0);
    do_cycle(1'b0, 3'd0, 1'b0);
    exp_stamp = tod(0, 0, 10);
    do_cycle(1'b1, 3'd3, 1'b0);
    do_cycle(1'b0, 3'd0, 1'b1);
    check("stale_stamp_lit", 32'(rd_data), 32'h0841A);
    do_cycle(1'b0, 3'd0, 1'b1);
    check("fresh_stamp_lit", 32'(rd_data), 32'h00053);
    check_status("drained");

    // Overwrite: 17 writes into 16 slots lose the first one.
    apply_reset(1'b0);
    horario = tod(23, 59, 59);
    settle();
    for (int i = 0; i < 17; i++) do_cycle(1'b1, 3'(i % 8), 1'b0);
    check("ovw_full", 32'(full), 32'd1);
    check("ovw_count", 32'(count), 32'd16);
    check("ovw_overflow", 32'(overflow), 32'd1);
    do_cycle(1'b0, 3'd0, 1'b1);
    check("ovw_first_lit", 32'(rd_data), 32'({tod(23, 59, 59), 3'd1}));
    for (int i = 1; i < 16; i++) do_cycle(1'b0, 3'd0, 1'b1);
    do_cycle(1'b0, 3'd0, 1'b0);
    check_status("ovw_drained");

    // Midnight wrap, then full with simultaneous write and pop: no overwrite.
    apply_reset(1'b0);
    horario = tod(0, 0, 0);
    settle();
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 3'(i % 8), 1'b0);
    check("fullrw_full", 32'(full), 32'd1);
    do_cycle(1'b1, 3'd7, 1'b1);
    check("fullrw_count", 32'(count), 32'd16);
    check("fullrw_overflow", 32'(overflow), 32'd0);
    check("fullrw_oldest_lit", 32'(rd_data), 32'h00000);
    for (int i = 0; i < 16; i++) do_cycle(1'b0, 3'd0, 1'b1);
    do_cycle(1'b0, 3'd0, 1'b0);
    check_status("fullrw_drained");

    // Empty with simultaneous write and pop: write lands, no bypass.
    do_cycle(1'b1, 3'd4, 1'b1);
    check("emptyrw_rd_valid", 32'(rd_valid), 32'd0);
    check("emptyrw_count", 32'(count), 32'd1);
    do_cycle(1'b0, 3'd0, 1'b1);
    do_cycle(1'b0, 3'd0, 1'b0);

    // Reset during a pop suppresses the strobe and clears the buffer.
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 3'(i), 1'b0);
    check("pre_reset_count", 32'(count), 32'd5);
    apply_reset(1'b1);
    check("midreset_rd_valid", 32'(rd_valid), 32'd0);
    check("midreset_count", 32'(count), 32'd0);
    check("midreset_empty", 32'(empty), 32'd1);

    repeat (3) do_cycle(1'b0, 3'd0, 1'b0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
